// File: rtl/bist_pkg.sv
// Shared BIST definitions: analyzer FSM encodings, default MISR constants and
// the MISR step function shared by the RTL and any golden-signature generator.
package bist_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_COMPACT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [7:0] DEF_POLY = 8'h1D;
  localparam logic [7:0] DEF_SEED = 8'h00;

  // Galois MISR step on a 32-bit container; only the low w bits are meaningful.
  function automatic logic [31:0] misr_step(input logic [31:0] s,
                                            input logic [31:0] d,
                                            input logic [31:0] poly,
                                            input int unsigned w);
    logic [31:0] mask;
    logic        msb;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msb  = |(s & (32'd1 << (w - 32'd1)));
    return ((s << 1) ^ (msb ? poly : 32'd0) ^ d) & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// W-bit Galois MISR: load forces SEED, en folds d into the signature; one-cycle update.
// sig_next exposes the value sig will take at the coming edge, with no flow control.
module bist_misr
  import bist_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = W'(DEF_POLY),
  parameter logic [W-1:0]   SEED = W'(DEF_SEED)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig,
  output logic [W-1:0] sig_next
);

  logic [W-1:0] step;

  always_comb begin
    step     = W'(misr_step(32'(sig), 32'(d), 32'(POLY), W));
    sig_next = sig;
    if (load) begin
      sig_next = SEED;
    end else if (en) begin
      sig_next = step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig <= SEED;
    end else begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_sig_analyzer.sv
// BIST response analyzer: MISR-compacts CUT responses while running, then issues a sticky
// pass/fail verdict one cycle after finish; all outputs registered, no backpressure.
module bist_sig_analyzer
  import bist_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(DEF_POLY),
  parameter logic [W-1:0] SEED = W'(DEF_SEED),
  parameter int           CW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          running,
  input  logic          finish,
  input  logic [W-1:0]  cut_resp,
  input  logic [W-1:0]  golden_sig,
  input  logic [CW-1:0] golden_cnt,
  output logic [W-1:0]  sig,
  output logic [CW-1:0] resp_cnt,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          err
);

  logic [1:0]    state;
  logic          active;
  logic          compact;
  logic          fin;
  logic          cnt_sat;
  logic [CW-1:0] cnt_next;
  logic          err_next;
  logic          err_verdict;
  logic          pass_verdict;
  logic [W-1:0]  sig_next;

  bist_misr #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk      (clk),
    .reset    (reset),
    .load     (init),
    .en       (compact),
    .d        (cut_resp),
    .sig      (sig),
    .sig_next (sig_next)
  );

  // init outranks running/finish; the compare sees this cycle's compaction already applied
  always_comb begin
    active       = (state == ST_ARMED) || (state == ST_COMPACT);
    compact      = active && running && !init;
    fin          = active && finish && !init;
    cnt_sat      = (resp_cnt == {CW{1'b1}});
    cnt_next     = (compact && !cnt_sat) ? resp_cnt + CW'(1) : resp_cnt;
    err_next     = err || (compact && cnt_sat);
    err_verdict  = err_next || (cnt_next == '0);
    pass_verdict = (sig_next == golden_sig) && (cnt_next == golden_cnt) && !err_verdict;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      resp_cnt <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      err      <= 1'b0;
    end else if (init) begin
      state    <= ST_ARMED;
      resp_cnt <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      err      <= 1'b0;
    end else if (active) begin
      resp_cnt <= cnt_next;
      err      <= err_next;
      if (fin) begin
        state <= ST_DONE;
        done  <= 1'b1;
        pass  <= pass_verdict;
        fail  <= !pass_verdict;
        err   <= err_verdict;
      end else if (compact) begin
        state <= ST_COMPACT;
      end
    end
  end

endmodule
